// File: rtl/pwm_bridge_gen.sv
// pwm_bridge_gen: edge-aligned complementary PWM command pair for nonoverlap, with graceful stop and brake.
// Define PWM_DEADTIME_COMP_EN to widen nonzero duties by DEADTIME, saturating at a full period.
module pwm_bridge_gen #(
  parameter int WIDTH    = 11,
  parameter int DEADTIME = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             brake,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_high,
  output logic             pwm_low,
  output logic             pwm_synch
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING, BRAKE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d, duty_eff;
  logic             high_q, high_d, low_q, low_d, synch_q, synch_d;
  logic             active, wrap, lt;
  if (DEADTIME < 0) begin : g_deadtime_check
    $error("DEADTIME must be non-negative");
  end
`ifdef PWM_DEADTIME_COMP_EN
  logic [WIDTH:0] duty_sum;
  assign duty_sum = {1'b0, duty} + (WIDTH+1)'(DEADTIME);
  assign duty_eff = duty == '0 ? '0 : duty_sum[WIDTH] ? '1 : duty_sum[WIDTH-1:0];
`else
  assign duty_eff = duty;
`endif
  assign active = state_q == RUN || state_q == STOPPING;
  assign wrap   = &cnt_q;
  assign lt     = cnt_q < duty_q;
  // Outputs reflect the pre-edge state/cnt, except brake which forces low-side immediately
  always_comb begin
    high_d  = !brake && active && lt;
    low_d   = brake || state_q == BRAKE || (active && !lt);
    synch_d = !brake && active && cnt_q == '0;
    state_d = state_q;
    cnt_d   = cnt_q + WIDTH'(1);
    duty_d  = duty_q;
    if (brake) begin
      state_d = BRAKE;
      cnt_d   = '0;
    end else if (!active) begin
      state_d = en ? RUN : IDLE;
      cnt_d   = '0;
      duty_d  = en ? duty_eff : duty_q;
    end else if (wrap) begin
      state_d = en ? RUN : state_q == RUN ? STOPPING : IDLE;
      duty_d  = (en || state_q == RUN) ? duty_eff : duty_q;
    end else if (!en) begin
      state_d = state_q == RUN ? STOPPING : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
      synch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      high_q  <= high_d;
      low_q   <= low_d;
      synch_q <= synch_d;
    end
  end
  assign pwm_high  = high_q;
  assign pwm_low   = low_q;
  assign pwm_synch = synch_q;
endmodule

// File: tb/tb_pwm_bridge_gen.sv
// tb_pwm_bridge_gen: randomized stimulus, period-level reference model feeding an expected-output queue.
module tb_pwm_bridge_gen;
  localparam int PER = 2048;
  localparam int DT  = 32;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, brake = 1'b0;
  logic [10:0] duty = 11'd512;
  logic pwm_high, pwm_low, pwm_synch;
  int checks = 0, failures = 0;
  logic [2:0] exp_q[$];
  bit m_on, m_stop_req, m_braked;
  int m_pos, m_duty;

  pwm_bridge_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake), .duty(duty),
    .pwm_high(pwm_high), .pwm_low(pwm_low), .pwm_synch(pwm_synch)
  );

  always #5 clk = ~clk;

  function automatic int eff(int d);
`ifdef PWM_DEADTIME_COMP_EN
    return d == 0 ? 0 : (d + DT > PER - 1 ? PER - 1 : d + DT);
`else
    return d;
`endif
  endfunction

  task automatic chk(string nm, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got={h,l,s}=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a period of PER cycles starts with m_duty high cycles; stop takes effect at period end
  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 0; m_stop_req = 0; m_braked = 0; m_pos = 0; m_duty = 0;
      exp_q.delete();
    end else begin
      if (brake || m_braked) exp_q.push_back(3'b010);
      else if (!m_on) exp_q.push_back(3'b000);
      else exp_q.push_back({m_pos < m_duty, m_pos >= m_duty, m_pos == 0});
      if (brake) begin
        m_braked = 1; m_on = 0; m_stop_req = 0;
      end else if (m_braked || !m_on) begin
        m_braked = 0; m_on = en; m_pos = 0; m_stop_req = 0;
        if (en) m_duty = eff(int'(duty));
      end else if (m_pos == PER - 1) begin
        m_pos = 0;
        if (en || !m_stop_req) m_duty = eff(int'(duty));
        if (!en && m_stop_req) m_on = 0;
        m_stop_req = !en;
      end else begin
        m_pos++;
        if (!en) m_stop_req = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) chk("reset_state", {pwm_high, pwm_low, pwm_synch}, 3'b000);
    else if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty got=none expected=entry at %0t", $time);
    end else chk("outputs", {pwm_high, pwm_low, pwm_synch}, exp_q.pop_front());
    checks++;
    if (pwm_high && pwm_low) begin
      failures++;
      $display("FAIL overlap got=high&low=1 expected=0 at %0t", $time);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(int p);
    for (int i = 0; i < 3 * PER; i++) begin
      @(negedge clk);
      if (m_on && !m_braked && m_pos == p) return;
    end
    checks++; failures++;
    $display("FAIL wait_pos got=timeout expected=pos %0d at %0t", p, $time);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    en = 1'b1;
    cyc(2 * PER + 10);
    wait_pos(50);
    duty = 11'd100;
    cyc(2 * PER);
    duty = 11'd0;
    wait_pos(5);
    cyc(2 * PER);
    duty = 11'd2047;
    cyc(2 * PER);
    duty = 11'd2030;
    cyc(2 * PER);
    duty = 11'd10;
    cyc(2 * PER);
    duty = 11'd700;
    wait_pos(300);
    en = 1'b0;
    cyc(PER + 100);
    en = 1'b1;
    wait_pos(300);
    en = 1'b0;
    wait_pos(2000);
    en = 1'b1;
    cyc(2 * PER);
    duty = 11'd1500;
    wait_pos(100);
    brake = 1'b1;
    cyc(20);
    brake = 1'b0;
    cyc(PER);
    wait_pos(400);
    brake = 1'b1;
    en = 1'b0;
    cyc(10);
    brake = 1'b0;
    cyc(30);
    en = 1'b1;
    wait_pos(700);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", {pwm_high, pwm_low, pwm_synch}, 3'b000);
    cyc(3);
    rst_n = 1'b1;
    cyc(PER + 50);
    for (int i = 0; i < 12; i++) begin
      duty = 11'($urandom_range(0, PER - 1));
      cyc($urandom_range(1, 2500));
      case ($urandom_range(0, 9))
        0, 1: begin
          brake = 1'b1;
          cyc($urandom_range(1, 5));
          brake = 1'b0;
        end
        2, 3, 4: en = !en;
        default: ;
      endcase
    end
    en = 1'b1;
    cyc(PER);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_bridge_gen.md
Name: pwm_bridge_gen

Overview:
- Produces the complementary high/low gate-command pair that feeds the `highIn`/`lowIn` inputs of `nonoverlap`, which sits between this block and the half-bridge drivers.
- Free-running edge-aligned PWM with a duty value held for a whole period, graceful stop, and brake.
- `pwm_synch` marks each period start so the control loop can update duty once per period.

Parameters:
- WIDTH, 11, counter/duty width; period = 2^WIDTH clocks.
- DEADTIME, 32, dead-time clocks that `nonoverlap` removes; used only by the optional feature.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run request; level-sensitive
- brake  input  1  force low-side on; highest priority
- duty  input  WIDTH  requested high-side cycles per period, unsigned
- pwm_high  output  1  high-side command to `nonoverlap` `highIn`
- pwm_low  output  1  low-side command to `nonoverlap` `lowIn`
- pwm_synch  output  1  one-cycle pulse on output cycle 0 of every period

Behaviour:
- Reset is asynchronous and active-low, and one clock is used.
- rst_n=0 gives state=IDLE, cnt=0, duty_r=0, pwm_high=0, pwm_low=0, pwm_synch=0.
- All outputs are registered and glitch-free, because `nonoverlap` triggers on input changes.
- Output latency is 1 clock after the state/cnt edge they reflect.
- States: IDLE, RUN, STOPPING, BRAKE.
- IDLE:
  - Outputs: pwm_high=0, pwm_low=0.
  - en=1 and brake=0 at an edge sets RUN, cnt<=0, duty_r<=duty_eff.
- RUN:
  - cnt increments each clock and wraps from 2^WIDTH-1 to 0.
  - duty_r<=duty_eff only on the wrap edge; it is never changed mid-period.
  - Outputs: pwm_high=(cnt<duty_r); pwm_low=!pwm_high.
  - pwm_synch=1 on the output cycle for cnt==0.
- en=0 in RUN sets STOPPING. STOPPING behaves as RUN until the wrap edge, then:
  - goes to IDLE if en=0, with outputs 0/0 from the next cycle;
  - goes back to RUN if en was reasserted, with no gap and duty latched as normal.
- brake=1 in any state:
  - next edge: state=BRAKE, cnt=0, pwm_high=0, pwm_low=1, pwm_synch=0;
  - stays in BRAKE while brake=1;
  - on brake=0: goes to RUN if en=1 (fresh period, cnt=0, duty latched), else IDLE.
- Duty boundaries:
  - duty_eff=0 gives pwm_high=0 for the whole period.
  - duty_eff=2^WIDTH-1 gives pwm_high=1 for all but the last cycle of each period.
  - No arithmetic wraps.
- Simultaneous events:
  - brake beats en and the wrap.
  - A wrap and an en deassert on the same edge: the wrap latches new duty and the state goes to STOPPING.
- rst_n asserted mid-period forces the reset values immediately, regardless of clk.

Optional Feature:
- Macro: PWM_DEADTIME_COMP_EN.
- Defined: duty_eff = (duty==0) ? 0 : min(duty+DEADTIME, 2^WIDTH-1), computed in WIDTH+1 bits and then saturated. This compensates for the pulse width that `nonoverlap` removes.
- Undefined: duty_eff = duty, and the DEADTIME parameter is unused.

Test Plan:
- Start/duty check:
  - Stimulus: reset, then en=1, duty=512, brake=0.
  - Response: after start, pwm_high=1 for exactly 512 clocks, then pwm_low=1 for 1536 clocks.
  - Response: pwm_synch pulses every 2048 clocks.
  - Response: pwm_high and pwm_low are never both 1.
- Mid-period duty change:
  - Stimulus: duty changed from 512 to 100 at cnt=50.
  - Response: the current period keeps 512 high cycles; the next period has 100.
- Extreme duty values:
  - duty=0 gives pwm_low=1 for the full period.
  - duty=2047 gives exactly one low cycle per period.
  - With PWM_DEADTIME_COMP_EN: duty=2030 saturates to 2047, and duty=10 gives 42 high cycles.
- Graceful stop and restart:
  - en=0 at cnt=300 gives completion to the end of the period, then pwm_high=pwm_low=0 and no further pwm_synch.
  - en re-raised at cnt=2000 while in STOPPING gives uninterrupted periods.
- Brake:
  - brake=1 mid-high-pulse gives pwm_high=0, pwm_low=1 on the next output cycle.
  - brake=0 with en=1 gives a fresh period with pwm_synch=1 on its first cycle.
- Reset:
  - rst_n=0 asserted between clock edges mid-period gives all outputs 0 immediately.
  - Release with en=1 restarts from cnt=0.
